// File: rtl/fsb_master_arbiter_pkg.sv
// Shared encodings for the front-side-bus master arbiter.
// State codes equal owner codes so the debug owner output is a direct view of the FSM.
package fsb_master_arbiter_pkg;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_M0   = 2'b01;
  localparam logic [1:0] OWN_M1   = 2'b10;

  localparam logic [1:0] ST_IDLE  = OWN_NONE;
  localparam logic [1:0] ST_OWN0  = OWN_M0;
  localparam logic [1:0] ST_OWN1  = OWN_M1;

endpackage

// File: rtl/fsb_master_arbiter_rr_pick.sv
// Two-way round-robin picker: on a tie the master that did not own the bus last wins.
module fsb_master_arbiter_rr_pick (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last_owner,
  output logic o_valid,
  output logic o_winner
);

  assign o_valid  = i_req0 | i_req1;
  assign o_winner = (i_req0 & i_req1) ? ~i_last_owner : i_req1;

endmodule

// File: rtl/fsb_master_arbiter.sv
// Arbitrates the single FSB data port between the cpu (m0) and the DMA/VGA master (m1).
// Round-robin with a burst cap; bus outputs are forced quiet whenever no grant is held.
module fsb_master_arbiter
  import fsb_master_arbiter_pkg::*;
#(
  parameter int unsigned MAX_BURST = 8,
  parameter int unsigned CNT_W     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic        m0_rw,
  output logic [31:0] m0_rdata,
  output logic        m0_done,
  output logic        m0_stall,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic        m1_rw,
  output logic [31:0] m1_rdata,
  output logic        m1_done,
  output logic        m1_stall,
  output logic [31:0] daddr,
  output logic [31:0] dout,
  output logic        drw,
  input  logic [31:0] din,
  input  logic        bus_ready,
  output logic [1:0]  owner
);

  localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(MAX_BURST - 1);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic             r_last_owner;
  logic             w_last_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic w_own0;
  logic w_own1;
  logic w_cur_req;
  logic w_oth_req;
  logic w_done;
  logic w_pick_valid;
  logic w_pick_winner;

  // Gating with rst keeps the strobe low in the very cycle reset rises.
  assign w_own0    = (r_state == ST_OWN0) & ~rst;
  assign w_own1    = (r_state == ST_OWN1) & ~rst;
  assign w_cur_req = w_own1 ? m1_req : m0_req;
  assign w_oth_req = w_own1 ? m0_req : m1_req;
  assign w_done    = (w_own0 | w_own1) & w_cur_req & bus_ready;

  fsb_master_arbiter_rr_pick u_pick (
    .i_req0       (m0_req),
    .i_req1       (m1_req),
    .i_last_owner (r_last_owner),
    .o_valid      (w_pick_valid),
    .o_winner     (w_pick_winner)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last_owner;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_OWN0, ST_OWN1: begin
        // Hand over on a dropped request, or on the capped done while the other side waits.
        if (!w_cur_req || (w_done && (r_cnt == LP_CNT_MAX) && w_oth_req)) begin
          w_state_nxt = w_oth_req ? ((r_state == ST_OWN1) ? ST_OWN0 : ST_OWN1) : ST_IDLE;
          w_last_nxt  = (r_state == ST_OWN1);
          w_cnt_nxt   = '0;
        end else if (w_done && (r_cnt != LP_CNT_MAX)) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        if (w_pick_valid) begin
          w_state_nxt = w_pick_winner ? ST_OWN1 : ST_OWN0;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_last_owner <= 1'b1;
      r_cnt        <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_owner <= w_last_nxt;
      r_cnt        <= w_cnt_nxt;
    end
  end

  always_comb begin
    daddr    = '0;
    dout     = '0;
    drw      = 1'b0;
    m0_rdata = '0;
    m1_rdata = '0;
    m0_done  = w_own0 & m0_req & bus_ready;
    m1_done  = w_own1 & m1_req & bus_ready;
    m0_stall = w_own0 ? (m0_req & ~bus_ready) : m0_req;
    m1_stall = w_own1 ? (m1_req & ~bus_ready) : m1_req;
    if (w_own0) begin
      daddr    = m0_addr;
      dout     = m0_wdata;
      drw      = m0_rw & m0_req;
      m0_rdata = din;
    end else if (w_own1) begin
      daddr    = m1_addr;
      dout     = m1_wdata;
      drw      = m1_rw & m1_req;
      m1_rdata = din;
    end
  end

  always_comb begin
    case (r_state)
      ST_OWN0: owner = OWN_M0;
      ST_OWN1: owner = OWN_M1;
      default: owner = OWN_NONE;
    endcase
  end

endmodule
